// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the 4-digit seven-segment scan controller.
//   NUM_DIGITS       : number of multiplexed digits
//   SEG_0..SEG_9     : segment patterns, active-high, bit order gfedcba (bit 6 = g)
//   SEG_BLANK        : all segments off
//   state_t          : scan controller state (IDLE, SCAN)
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_bcd_decode.sv
// -----------------------------------------------------------------------------
// seg7_bcd_decode
// Purely combinational BCD to seven-segment decoder. Non-BCD codes (10-15)
// produce a blank digit.
// Ports:
//   bcd  [3:0] in  : BCD digit value
//   seg  [6:0] out : active-high segments gfedcba
// -----------------------------------------------------------------------------
module seg7_bcd_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// -----------------------------------------------------------------------------
// seg7_scan_controller
// Time-multiplexed driver for a 4-digit common-anode/cathode seven-segment
// display. Holds four BCD digit registers, scans them with a programmable
// dwell time and emits a pulse once per completed frame.
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros
// on digits 3..1 (digit 0 is always shown).
//
// Parameters:
//   DIV_W   : prescaler width
//   DIV_MAX : dwell cycles per digit minus one (must fit in DIV_W bits)
// Ports:
//   clk_in          in  : clock, rising edge
//   rst_in          in  : asynchronous active-high reset
//   enable          in  : scan enable
//   wr_en           in  : digit register write strobe
//   wr_addr   [1:0] in  : digit index to write (0 = least significant)
//   wr_data   [3:0] in  : BCD value to write
//   dig_sel   [3:0] out : active-low one-hot digit enable, bit i = digit i
//   seg       [6:0] out : active-high segments gfedcba
//   frame_done      out : one-cycle pulse when digit 0 reappears after digit 3
// -----------------------------------------------------------------------------
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DIV_MAX = 49999
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [3:0] dig_sel,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam logic [DIV_W-1:0] DIV_MAX_W = DIV_W'(DIV_MAX);

    // ------------------------------------------------------------------
    // Digit registers (writable in any state)
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0][3:0] digit_vals;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] val_reg;

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    val_reg <= 4'd0;
                end else if (wr_en && (wr_addr == 2'(gi))) begin
                    val_reg <= wr_data;
                end
            end

            assign digit_vals[gi] = val_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Leading-zero blanking mask: a digit is blanked only when it and every
    // more significant digit are zero. Digit 0 is never blanked.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] blank_mask;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign blank_mask[3] = (digit_vals[3] == 4'd0);
    assign blank_mask[2] = blank_mask[3] && (digit_vals[2] == 4'd0);
    assign blank_mask[1] = blank_mask[2] && (digit_vals[1] == 4'd0);
    assign blank_mask[0] = 1'b0;
`else
    assign blank_mask = '0;
`endif

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [DIV_W-1:0] presc_reg, presc_next;
    logic [1:0]       idx_reg,   idx_next;
    // Set for the single cycle after the index wraps 3 -> 0; the output
    // stage turns it into frame_done together with the digit-0 output.
    logic             wrap_reg,  wrap_next;

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        idx_next   = idx_reg;
        wrap_next  = 1'b0;

        if (!enable) begin
            // Leaving (or staying in) IDLE discards any partial dwell.
            state_next = IDLE;
            presc_next = '0;
            idx_next   = 2'd0;
        end else if (state_reg == IDLE) begin
            state_next = SCAN;
            presc_next = '0;
            idx_next   = 2'd0;
        end else if (presc_reg == DIV_MAX_W) begin
            presc_next = '0;
            idx_next   = idx_reg + 2'd1;
            wrap_next  = (idx_reg == 2'd3);
        end else begin
            presc_next = presc_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output path: one decoder, fed from the currently selected digit.
    // ------------------------------------------------------------------
    logic [6:0] decoded_seg;
    logic [6:0] shown_seg;

    seg7_bcd_decode u_decode (
        .bcd (digit_vals[idx_reg]),
        .seg (decoded_seg)
    );

    assign shown_seg = blank_mask[idx_reg] ? SEG_BLANK : decoded_seg;

    logic [3:0] dig_sel_reg, dig_sel_next;
    logic [6:0] seg_reg,     seg_next;
    logic       frame_reg,   frame_next;

    // Outputs follow the state/index of the previous cycle, so IDLE values
    // appear one cycle after the state register itself returns to IDLE.
    always_comb begin
        dig_sel_next = 4'b1111;
        seg_next     = SEG_BLANK;
        frame_next   = 1'b0;
        if (state_reg == SCAN) begin
            dig_sel_next = ~(4'b0001 << idx_reg);
            seg_next     = shown_seg;
            frame_next   = wrap_reg;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg   <= IDLE;
            presc_reg   <= '0;
            idx_reg     <= 2'd0;
            wrap_reg    <= 1'b0;
            dig_sel_reg <= 4'b1111;
            seg_reg     <= SEG_BLANK;
            frame_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            idx_reg     <= idx_next;
            wrap_reg    <= wrap_next;
            dig_sel_reg <= dig_sel_next;
            seg_reg     <= seg_next;
            frame_reg   <= frame_next;
        end
    end

    assign dig_sel    = dig_sel_reg;
    assign seg        = seg_reg;
    assign frame_done = frame_reg;

endmodule
